ascii_case_stream: RTL
======================

Name: ascii_case_stream

Overview:
- Streaming, multi-lane successor to the combinational toUpper converter.
- Accepts LANES bytes per beat over a valid/ready handshake and applies a runtime-selected case transform to each byte: pass, upper, lower or toggle.
- Registers the result behind a 2-entry skid buffer, so full throughput is held under backpressure.
- Keeps a saturating count of bytes actually changed; sits between a byte-stream source (UART RX, FIFO) and a sink.

Parameters:
- LANES, 4, bytes per beat (1..16).
- COUNT_W, 16, width of the converted-byte counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  transform select: 00 pass, 01 upper, 10 lower, 11 toggle; sampled per accepted beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  8*LANES  input bytes; lane k = bits [8k+7:8k].
- in_keep  in  LANES  per-lane byte-valid.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.
- out_data  out  8*LANES  transformed bytes.
- out_keep  out  LANES  in_keep passed through unchanged.
- clear_count  in  1  synchronous clear of conv_count.
- conv_count  out  COUNT_W  saturating count of changed bytes.

Behaviour:
- Reset: out_valid=0, out_data=0, out_keep=0, conv_count=0, skid empty, in_ready=0 while rst=1.
- First cycle after reset deasserts: in_ready=1.
- Transfer handshake: an input beat transfers when in_valid&in_ready at a rising edge; an output beat transfers when out_valid&out_ready.
- Latency: an accepted beat appears on out_data exactly 1 cycle later when the output register is free.
- Throughput: 1 beat/cycle when out_ready=1.
- Per-lane transform, applied identically to every lane:
  - upper: 0x61..0x7A minus 0x20.
  - lower: 0x41..0x5A plus 0x20.
  - toggle: bit 5 flipped for either range.
  - pass: unchanged.
  - All other values unchanged, including 0x00..0x40, 0x5B..0x60, 0x7B..0xFF and every byte >=0x80.
- Lanes with keep=0 pass through unchanged, are not counted, and still appear in out_data.
- Mode changes take effect on the next accepted beat; beats already buffered keep the mode they were accepted with.
- Skid buffer:
  - Output register full and out_ready=0 while a beat is accepted: the beat goes to the skid register and in_ready drops the next cycle.
  - When the output drains, the skid beat moves to the output register and in_ready returns to 1 the following cycle.
  - in_ready is a registered output, with no combinational path from out_ready.
  - Order is preserved; no beat is lost or duplicated.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_keep hold stable.
- conv_count:
  - Adds the popcount of changed, kept lanes for each accepted beat, in the cycle after acceptance.
  - Saturates at 2^COUNT_W-1 with no wrap.
  - clear_count has priority over a same-cycle increment: the result is 0.
- Reset mid-operation: buffered beats are discarded, outputs take reset values the next edge, and no partial beat is emitted.
- in_valid while in_ready=0: ignored; the source must hold its data.

Decomposition:
- Package ascii_case_pkg:
  - Mode constants MODE_PASS/UPPER/LOWER/TOGGLE.
  - ASCII bounds CH_a=0x61, CH_z=0x7A, CH_A=0x41, CH_Z=0x5A.
  - CASE_BIT=5.
- Sub-module ascii_case_lane: one byte in, mode, keep -> byte out plus changed flag.
  - Purely combinational.
  - Instantiated LANES times via generate.
- Top level holds the skid buffer, output register and counter.

Test Plan:
- Upper mode, out_ready=1, LANES=4, in_data bytes {0x61,0x7A,0x7B,0x40}, keep=1111 -> next cycle out_data {0x41,0x5A,0x7B,0x40}, conv_count=2.
- Lower, then toggle mode, consecutive beats {0x48,0x5A,0x5B,0xC8} and {0x61,0x41,0x30,0x7F} -> {0x68,0x7A,0x5B,0xC8} then {0x41,0x61,0x30,0x7F}; back-to-back with no bubbles.
- Keep mask: upper mode, {0x61,0x62,0x63,0x64}, keep=0101 -> out {0x41,0x62,0x43,0x64}, out_keep=0101, count +2.
- Backpressure: out_ready=0, three beats offered -> first two accepted, in_ready=0 from the cycle after the second; out_ready=1 -> beats emitted in order, third accepted, none lost.
- Counter: COUNT_W=4, 5 upper beats of four 'a' -> conv_count saturates at 15; clear_count together with an accepted beat -> 0.
- Reset mid-stream with out_valid=1 and skid full -> next edge out_valid=0, conv_count=0; first post-reset beat is the only output.

Source files
------------

// File: rtl/ascii_case_pkg.sv
// Shared definitions for the streaming ASCII case converter:
// transform modes, letter bounds and a range helper.
package ascii_case_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_UPPER  = 2'b01,
    MODE_LOWER  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  localparam logic [7:0] CH_a = 8'h61;
  localparam logic [7:0] CH_z = 8'h7A;
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_Z = 8'h5A;

  localparam int CASE_BIT = 5;

  function automatic logic in_range(
    input logic [7:0] b,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/ascii_case_lane.sv
// One byte lane of the case converter: combinational
// transform plus a flag telling whether the byte changed.
module ascii_case_lane
  import ascii_case_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic [1:0] i_mode,
  input  logic       i_keep,
  output logic [7:0] o_byte,
  output logic       o_changed
);

  logic       w_is_lo;
  logic       w_is_up;
  logic [7:0] w_res;

  assign w_is_lo = in_range(i_byte, CH_a, CH_z);
  assign w_is_up = in_range(i_byte, CH_A, CH_Z);

  // Letters differ only in the case bit; everything else passes.
  always_comb begin
    w_res = i_byte;
    unique case (mode_e'(i_mode))
      MODE_PASS: ;
      MODE_UPPER: begin
        if (w_is_lo) w_res[CASE_BIT] = 1'b0;
      end
      MODE_LOWER: begin
        if (w_is_up) w_res[CASE_BIT] = 1'b1;
      end
      MODE_TOGGLE: begin
        if (w_is_lo || w_is_up)
          w_res[CASE_BIT] = ~i_byte[CASE_BIT];
      end
    endcase
  end

  // Unkept lanes ride through untouched and never count.
  assign o_byte    = i_keep ? w_res : i_byte;
  assign o_changed = i_keep && (w_res != i_byte);

endmodule

// File: rtl/ascii_case_stream.sv
// Multi-lane streaming case converter with a 2-entry skid
// buffer (output reg + skid reg) and a changed-byte counter.
module ascii_case_stream
  import ascii_case_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [LANES-1:0]     in_keep,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [LANES-1:0]     out_keep,
  input  logic                 clear_count,
  output logic [COUNT_W-1:0]   conv_count
);

  localparam int DW = 8 * LANES;
  localparam int PW = $clog2(LANES + 1);
  localparam int SW = COUNT_W + PW;

  localparam logic [SW-1:0] SAT =
    {{PW{1'b0}}, {COUNT_W{1'b1}}};

  logic [DW-1:0]      w_xf_data;
  logic [LANES-1:0]   w_chg;
  logic [PW-1:0]      w_pop;
  logic [SW-1:0]      w_sum;
  logic [COUNT_W-1:0] w_count_inc;

  logic               w_accept;
  logic               w_load;
  logic               w_skid_next;

  logic               r_in_ready;
  logic               r_out_valid;
  logic [DW-1:0]      r_out_data;
  logic [LANES-1:0]   r_out_keep;
  logic               r_skid_valid;
  logic [DW-1:0]      r_skid_data;
  logic [LANES-1:0]   r_skid_keep;
  logic [COUNT_W-1:0] r_count;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ascii_case_lane u_lane (
      .i_byte    (in_data[8*g +: 8]),
      .i_mode    (mode),
      .i_keep    (in_keep[g]),
      .o_byte    (w_xf_data[8*g +: 8]),
      .o_changed (w_chg[g])
    );
  end

  assign w_accept = in_valid && r_in_ready;
  assign w_load   = !r_out_valid || out_ready;

  // Skid occupancy after this edge; in_ready is its registered inverse.
  always_comb begin
    w_skid_next = r_skid_valid;
    if (w_load)
      w_skid_next = 1'b0;
    else if (w_accept)
      w_skid_next = 1'b1;
  end

  // Output register refills from skid first to keep beat order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_keep  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_in_ready   <= !w_skid_next;
      r_skid_valid <= w_skid_next;
      if (w_load) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_keep  <= r_skid_keep;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_xf_data;
          r_out_keep  <= in_keep;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_data <= w_xf_data;
        r_skid_keep <= in_keep;
      end
    end
  end

  // Number of kept lanes altered in the offered beat.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < LANES; i++)
      w_pop = w_pop + PW'(w_chg[i]);
  end

  // Widened add so the saturation test cannot itself wrap.
  always_comb begin
    w_sum = SW'(r_count) + SW'(w_pop);
    if (w_sum > SAT)
      w_count_inc = '1;
    else
      w_count_inc = w_sum[COUNT_W-1:0];
  end

  // Counter: clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (clear_count)
      r_count <= '0;
    else if (w_accept)
      r_count <= w_count_inc;
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_keep   = r_out_keep;
  assign conv_count = r_count;

endmodule
